// File: rtl/pdn_domain_sequencer.sv
// pdn_domain_sequencer: serialises power-switch enables for NUM_DOM supply
// domains, caps how many are on at once, settles on power-good, flags timeouts.
// Ports: clk, rst (sync, active-high), dom_req, dom_pg, fault_clr in;
// dom_en, dom_ack, fault, busy out (all registered).
module pdn_domain_sequencer #(
  parameter int NUM_DOM     = 6,
  parameter int SETTLE_CYC  = 4,
  parameter int DRAIN_CYC   = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_ON      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DOM-1:0] dom_req,
  input  logic [NUM_DOM-1:0] dom_pg,
  input  logic [NUM_DOM-1:0] fault_clr,
  output logic [NUM_DOM-1:0] dom_en,
  output logic [NUM_DOM-1:0] dom_ack,
  output logic [NUM_DOM-1:0] fault,
  output logic               busy
);

  localparam int IW   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int PW   = $clog2(NUM_DOM + 1);
  localparam int CMAX = (TIMEOUT_CYC > DRAIN_CYC) ? TIMEOUT_CYC
                                                  : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ON_WAIT,
    OFF_DRAIN
  } state_t;

  state_t          state;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   pg_cnt;

  logic [NUM_DOM-1:0] off_pend;
  logic [NUM_DOM-1:0] on_pend;
  logic [PW-1:0]      en_cnt;
  logic               budget_ok;
  logic [IW:0]        off_pick;
  logic [IW:0]        on_pick;
  logic [CW-1:0]      cnt_nx;
  logic [CW-1:0]      pg_nx;
  logic [IW-1:0]      sel_inc;

  // Round-robin search starting at p; returns {hit, index}.
  function automatic logic [IW:0] rr_pick(
    input logic [NUM_DOM-1:0] m,
    input logic [IW-1:0]      p
  );
    logic [IW:0] r;
    int          j;
    r = '0;
    for (int k = NUM_DOM - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_DOM) j = j - NUM_DOM;
      if (m[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  always_comb begin
    en_cnt = '0;
    for (int i = 0; i < NUM_DOM; i++)
      en_cnt = en_cnt + PW'(dom_en[i]);
  end

  assign off_pend  = ~dom_req & dom_en;
  assign on_pend   = dom_req & ~dom_en & ~fault;
  assign budget_ok = en_cnt < PW'(MAX_ON);
  assign off_pick  = rr_pick(off_pend, rr_ptr);
  assign on_pick   = rr_pick(on_pend, rr_ptr);
  assign cnt_nx    = cnt + CW'(1);
  assign pg_nx     = dom_pg[sel] ? pg_cnt + CW'(1) : '0;
  assign sel_inc   = (sel == IW'(NUM_DOM - 1)) ? '0
                                              : sel + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      pg_cnt  <= '0;
      dom_en  <= '0;
      dom_ack <= '0;
      fault   <= '0;
      busy    <= 1'b0;
    end else begin
      // A timeout set below overrides a same-cycle clear.
      fault <= fault & ~fault_clr;
      unique case (state)
        IDLE: begin
          if (off_pick[IW]) begin
            dom_ack[off_pick[IW-1:0]] <= 1'b0;
            sel   <= off_pick[IW-1:0];
            cnt   <= '0;
            state <= OFF_DRAIN;
            busy  <= 1'b1;
          end else if (on_pick[IW] && budget_ok) begin
            dom_en[on_pick[IW-1:0]] <= 1'b1;
            sel    <= on_pick[IW-1:0];
            cnt    <= '0;
            pg_cnt <= '0;
            state  <= ON_WAIT;
            busy   <= 1'b1;
          end
        end
        ON_WAIT: begin
          cnt    <= cnt_nx;
          pg_cnt <= pg_nx;
          if (pg_nx == CW'(SETTLE_CYC)) begin
            dom_ack[sel] <= 1'b1;
            rr_ptr <= sel_inc;
            state  <= IDLE;
            busy   <= 1'b0;
          end else if (cnt_nx == CW'(TIMEOUT_CYC)) begin
            dom_en[sel] <= 1'b0;
            fault[sel]  <= 1'b1;
            rr_ptr <= sel_inc;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        OFF_DRAIN: begin
          cnt <= cnt_nx;
          if (cnt_nx == CW'(DRAIN_CYC)) begin
            dom_en[sel] <= 1'b0;
            rr_ptr <= sel_inc;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdn_domain_sequencer.sv
// tb_pdn_domain_sequencer: directed and random stimulus against a
// behavioural model of the domain sequencer; prints one summary line.
module tb_pdn_domain_sequencer;

  localparam int N     = 6;
  localparam int SET   = 4;
  localparam int DRN   = 2;
  localparam int TMO   = 16;
  localparam int MAXON = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] dom_req;
  logic [N-1:0] dom_pg;
  logic [N-1:0] fault_clr;
  logic [N-1:0] dom_en;
  logic [N-1:0] dom_ack;
  logic [N-1:0] fault;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // model: op 0 = idle, 1 = powering up, 2 = draining
  logic [N-1:0] m_en, m_ack, m_fault;
  int m_op, m_who, m_el, m_st, m_rr;

  logic [N-1:0] pg_good;
  int           glitch_pct;
  bit           auto_pg;

  always #5 clk = ~clk;

  pdn_domain_sequencer #(
    .NUM_DOM    (N),
    .SETTLE_CYC (SET),
    .DRAIN_CYC  (DRN),
    .TIMEOUT_CYC(TMO),
    .MAX_ON     (MAXON)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dom_req  (dom_req),
    .dom_pg   (dom_pg),
    .fault_clr(fault_clr),
    .dom_en   (dom_en),
    .dom_ack  (dom_ack),
    .fault    (fault),
    .busy     (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_find(input logic [N-1:0] m,
                                 input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] off_p, on_p, nf;
    int d;
    if (rst) begin
      m_en = '0; m_ack = '0; m_fault = '0;
      m_op = 0; m_who = 0; m_el = 0;
      m_st = 0; m_rr = 0;
      return;
    end
    nf = m_fault & ~fault_clr;
    case (m_op)
      0: begin
        off_p = ~dom_req & m_en;
        on_p  = dom_req & ~m_en & ~m_fault;
        if (off_p != 0) begin
          d = rr_find(off_p, m_rr);
          m_ack[d] = 1'b0;
          m_op = 2; m_who = d; m_el = 0;
        end else if (on_p != 0 &&
                     $countones(m_en) < MAXON) begin
          d = rr_find(on_p, m_rr);
          m_en[d] = 1'b1;
          m_op = 1; m_who = d; m_el = 0; m_st = 0;
        end
      end
      1: begin
        m_el++;
        m_st = dom_pg[m_who] ? m_st + 1 : 0;
        if (m_st == SET) begin
          m_ack[m_who] = 1'b1;
          m_rr = (m_who + 1) % N;
          m_op = 0;
        end else if (m_el == TMO) begin
          m_en[m_who] = 1'b0;
          nf[m_who] = 1'b1;
          m_rr = (m_who + 1) % N;
          m_op = 0;
        end
      end
      default: begin
        m_el++;
        if (m_el == DRN) begin
          m_en[m_who] = 1'b0;
          m_rr = (m_who + 1) % N;
          m_op = 0;
        end
      end
    endcase
    m_fault = nf;
  endtask

  // Entered at negedge with inputs set; returns at next negedge.
  task automatic tick();
    if (auto_pg) begin
      dom_pg = m_en & pg_good;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < glitch_pct)
          dom_pg[i] = 1'b0;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("en",    dom_en,  m_en);
    chk("ack",   dom_ack, m_ack);
    chk("fault", fault,   m_fault);
    chk("busy",  busy,    m_op != 0);
    chk("ack_wo_en", dom_ack & ~dom_en, 0);
    chk("cap", $countones(dom_en) > MAXON, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dom_req = '0;
    fault_clr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int en_at, ack_at, bcnt, lim;
    bit seen;
    rst = 1'b1;
    dom_req = '0;
    dom_pg = '0;
    fault_clr = '0;
    pg_good = '1;
    glitch_pct = 0;
    auto_pg = 1'b1;
    m_en = '0; m_ack = '0; m_fault = '0;
    m_op = 0; m_who = 0; m_el = 0; m_st = 0; m_rr = 0;
    @(negedge clk);
    do_reset();
    chk("rst_out", {dom_en, dom_ack, fault, busy}, 0);

    // single domain latency
    dom_req = 6'b000001;
    en_at = -1; ack_at = -1; bcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (busy) bcnt++;
      if (dom_en[0] && en_at < 0) en_at = c;
      if (dom_ack[0] && ack_at < 0) ack_at = c;
    end
    chk("lat_en", en_at, 1);
    chk("lat_ack", ack_at - en_at, SET);
    chk("busy_len", bcnt, SET);

    // all requested: cap and order
    do_reset();
    dom_req = 6'b111111;
    tick();
    chk("first_dom", dom_en, 6'b000001);
    for (int c = 0; c < 40; c++) tick();
    chk("cap_set", dom_en, 6'b001111);
    dom_req = 6'b111101;
    tick();
    chk("off_ack", dom_ack[1], 0);
    chk("off_en_held", dom_en[1], 1);
    tick();
    tick();
    chk("off_en", dom_en[1], 0);
    for (int c = 0; c < 12; c++) tick();
    chk("dom4_up", dom_ack[4], 1);

    // stuck power-good -> fault, then clear and retry
    do_reset();
    pg_good = 6'b111011;
    dom_req = 6'b000100;
    for (int c = 0; c < TMO + 4; c++) tick();
    chk("stuck_fault", fault[2], 1);
    chk("stuck_off", dom_en[2], 0);
    for (int c = 0; c < 10; c++) tick();
    chk("no_retry", dom_en[2], 0);
    fault_clr = 6'b000100;
    tick();
    fault_clr = '0;
    tick();
    chk("retry", dom_en[2], 1);
    pg_good = '1;
    for (int c = 0; c < 8; c++) tick();

    // pg streak broken by one low cycle
    do_reset();
    dom_req = 6'b001000;
    auto_pg = 1'b0;
    dom_pg = '0;
    tick();
    begin
      logic [6:0] pat;
      pat = 7'b1111011;
      seen = 0;
      for (int k = 0; k < 7; k++) begin
        if (dom_ack[3]) seen = 1;
        dom_pg = {2'b00, pat[k], 3'b000};
        tick();
      end
      chk("streak_early", seen, 0);
      chk("streak_ack", dom_ack[3], 1);
    end
    auto_pg = 1'b1;

    // rr pointer and off-before-on priority
    do_reset();
    dom_req = 6'b100000;
    for (int c = 0; c < 8; c++) tick();
    dom_req = 6'b100001;
    for (int c = 0; c < 8; c++) tick();
    dom_req = 6'b100000;
    for (int c = 0; c < 6; c++) tick();
    dom_req = 6'b100011;
    tick();
    chk("rr_first", dom_en, 6'b100010);
    dom_req = 6'b000011;
    lim = 0;
    while (dom_en[5] && lim < 30) begin
      tick();
      lim++;
    end
    chk("off_timeout", lim < 30, 1);
    chk("off_before_on", dom_en[0], 0);
    for (int c = 0; c < 8; c++) tick();

    // reset mid power-up and mid drain
    dom_req = 6'b000100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_on", {dom_en, dom_ack, busy}, 0);
    rst = 1'b0;
    dom_req = 6'b000001;
    for (int c = 0; c < 8; c++) tick();
    dom_req = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_off", {dom_en, dom_ack, busy}, 0);
    rst = 1'b0;

    // randomized segments
    for (int s = 0; s < 80; s++) begin
      dom_req = N'($urandom);
      pg_good = '1;
      if ($urandom_range(0, 2) == 0)
        pg_good[$urandom_range(0, N - 1)] = 1'b0;
      glitch_pct = $urandom_range(0, 15);
      for (int c = 0; c < 40; c++) begin
        fault_clr = '0;
        if ($urandom_range(0, 19) == 0)
          fault_clr = N'($urandom);
        rst = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 29) == 0)
          dom_req = N'($urandom);
        tick();
      end
    end
    rst = 1'b0;
    fault_clr = '0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
